// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: receiving end of a toggle-signalled event link.
// Each level change on tgl_in is one event. The line is synchronised and
// edge-detected into a one-cycle pulse. Events are queued in a saturating
// pending counter that the consumer drains one at a time.
//
// Handshake: the consumer takes one event on every rising edge where
// evt_valid && evt_ready. evt_valid stays high while events are pending.
// evt_ready has no effect while evt_valid is low.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgl_in,
    output logic             evt_pulse,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [TOT_W-1:0] tot_cnt,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             dbg_state
);

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Warm-up lasts SYNC_STAGES+1 edges. During that time the sync chain and
    // prev fill with the line level present at reset release.
    localparam logic [2:0]       ARM_LAST = 3'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         arm_cnt;
    logic [2:0]         arm_cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               ssync;
    logic               prev_q;
    logic               det;
    logic               inc;
    logic               dec;
    logic               ovf_set;
    logic               ovf_nxt;
    logic [CNT_W-1:0]   pend_nxt;
    logic [TOT_W-1:0]   tot_nxt;

    assign ssync     = sync_q[SYNC_STAGES-1];
    assign dbg_state = state;

    // Synchroniser chain and previous-level register; both run in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
            prev_q <= ssync;
        end
    end

    // FSM state register and warm-up edge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WARMUP;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
        end
    end

    // Next state. Edge detection is enabled only once warm-up has finished.
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        det         = 1'b0;
        case (state)
            WARMUP: begin
                if (arm_cnt == ARM_LAST) begin
                    state_nxt = RUN;
                end else begin
                    arm_cnt_nxt = arm_cnt + 3'd1;
                end
            end
            RUN: begin
                det = ssync ^ prev_q;
            end
            default: begin
                state_nxt = WARMUP;
            end
        endcase
    end

    // Pending/total counter arithmetic and sticky-overflow set/clear.
    // When inc and dec coincide the counter stays put, even at max, so that
    // case never counts as an overflow.
    always_comb begin
        inc      = det;
        dec      = evt_valid & evt_ready;
        pend_nxt = pend_cnt;
        ovf_set  = 1'b0;
        if (inc && !dec) begin
            if (pend_cnt == PEND_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_nxt = pend_cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            pend_nxt = pend_cnt - 1'b1;
        end
        tot_nxt = det ? tot_cnt + 1'b1 : tot_cnt;
        if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf;
        end
    end

    // Output registers. evt_valid comes from pend_nxt, so it always matches
    // (pend_cnt != 0) in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_pulse <= 1'b0;
            evt_valid <= 1'b0;
            pend_cnt  <= '0;
            tot_cnt   <= '0;
            ovf       <= 1'b0;
        end else begin
            evt_pulse <= det;
            evt_valid <= (pend_nxt != '0);
            pend_cnt  <= pend_nxt;
            tot_cnt   <= tot_nxt;
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Testbench for toggle_event_decoder: directed toggle sequences, a
// history-based behavioural model checked every cycle, and literal
// checkpoints at the interesting moments.
module tb_toggle_event_decoder;

    localparam int SS    = 2;
    localparam int CW    = 4;
    localparam int TW    = 16;
    localparam int PMAX  = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          tgl_in;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_pulse;
    logic          evt_valid;
    logic [CW-1:0] pend_cnt;
    logic [TW-1:0] tot_cnt;
    logic          ovf;
    logic          dbg_state;

    always #5 clk = ~clk;

    toggle_event_decoder #(
        .SYNC_STAGES (SS),
        .CNT_W       (CW),
        .TOT_W       (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgl_in    (tgl_in),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pend_cnt  (pend_cnt),
        .tot_cnt   (tot_cnt),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .dbg_state (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist_q holds the line level sampled at each edge since reset release.
    // An event is seen SS edges after its first sample, once the block has run
    // SS+1 warm-up edges.
    logic hist_q[$];
    int   m_n = 0;
    int   m_pend = 0;
    int   m_tot = 0;
    int   m_ovf = 0;
    int   m_pulse = 0;
    int   m_run = 0;

    always @(posedge clk) begin
        int  sz;
        int  det;
        int  dec;
        int  oset;
        if (!rst_n) begin
            m_n = 0;
            hist_q.delete();
            m_pend = 0;
            m_tot = 0;
            m_ovf = 0;
            m_pulse = 0;
            m_run = 0;
        end else begin
            m_n++;
            hist_q.push_back(tgl_in);
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            det = 0;
            if (m_n >= SS + 2) begin
                sz = hist_q.size();
                det = (hist_q[sz-1-SS] != hist_q[sz-2-SS]) ? 1 : 0;
            end
            dec  = (m_pend != 0 && evt_ready) ? 1 : 0;
            oset = 0;
            if (det == 1 && dec == 0) begin
                if (m_pend == PMAX) oset = 1;
                else m_pend = m_pend + 1;
            end else if (dec == 1 && det == 0) begin
                m_pend = m_pend - 1;
            end
            if (oset == 1) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_tot   = (m_tot + det) % (1 << TW);
            m_pulse = det;
            m_run   = (m_n >= SS + 1) ? 1 : 0;
        end
        #1;
        chk("pulse", int'(evt_pulse), m_pulse);
        chk("valid", int'(evt_valid), (m_pend != 0) ? 1 : 0);
        chk("pend",  int'(pend_cnt),  m_pend);
        chk("tot",   int'(tot_cnt),   m_tot);
        chk("ovf",   int'(ovf),       m_ovf);
        chk("state", int'(dbg_state), m_run);
        if (evt_pulse) pulse_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic lvl);
        @(negedge clk);
        rst_n     = 1'b0;
        tgl_in    = lvl;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SS + 4) @(negedge clk);
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            tgl_in = ~tgl_in;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int base;
        rst_n     = 1'b0;
        tgl_in    = 1'b1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pend",  int'(pend_cnt),  0);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_tot",   int'(tot_cnt),   0);
        chk("rst_state", int'(dbg_state), 0);

        // 1: line already high at release is absorbed
        base = pulse_seen;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t1_pulses", pulse_seen - base, 0);
        chk("t1_pend", int'(pend_cnt), 0);
        chk("t1_tot",  int'(tot_cnt),  0);

        // 2: single toggle, pulse after third edge, then one accept
        do_reset(1'b0);
        tgl_in = 1'b1;
        @(posedge clk); #2 chk("t2_pulse_e0", int'(evt_pulse), 0);
        @(posedge clk); #2 chk("t2_pulse_e1", int'(evt_pulse), 0);
        @(posedge clk); #2 chk("t2_pulse_e2", int'(evt_pulse), 1);
        chk("t2_pend", int'(pend_cnt), 1);
        chk("t2_valid", int'(evt_valid), 1);
        @(posedge clk); #2 chk("t2_pulse_e3", int'(evt_pulse), 0);
        @(negedge clk); evt_ready = 1'b1;
        @(posedge clk); #2 chk("t2_pend_acc", int'(pend_cnt), 0);
        chk("t2_valid_acc", int'(evt_valid), 0);
        @(negedge clk); evt_ready = 1'b0;

        // 3: five spaced toggles, then drain on consecutive edges
        do_reset(1'b0);
        base = pulse_seen;
        toggles(5);
        chk("t3_pend", int'(pend_cnt), 5);
        chk("t3_tot", int'(tot_cnt), 5);
        chk("t3_pulses", pulse_seen - base, 5);
        evt_ready = 1'b1;
        for (int k = 4; k >= 0; k--) begin
            @(posedge clk); #2 chk("t3_drain", int'(pend_cnt), k);
        end
        @(negedge clk); evt_ready = 1'b0;
        chk("t3_valid_end", int'(evt_valid), 0);

        // 4: saturation and overflow, then clear
        do_reset(1'b0);
        toggles(17);
        chk("t4_pend", int'(pend_cnt), 15);
        chk("t4_ovf", int'(ovf), 1);
        chk("t4_tot", int'(tot_cnt), 17);
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        chk("t4_ovf_clr", int'(ovf), 0);
        chk("t4_pend_kept", int'(pend_cnt), 15);

        // 5: inc and dec on the same edge, at max and at 3
        tgl_in = ~tgl_in;
        repeat (2) @(negedge clk);
        evt_ready = 1'b1;
        @(posedge clk); #2 chk("t5_pend_max", int'(pend_cnt), 15);
        chk("t5_ovf", int'(ovf), 0);
        chk("t5_pulse", int'(evt_pulse), 1);
        @(negedge clk);
        repeat (12) @(negedge clk);
        evt_ready = 1'b0;
        chk("t5_pend3", int'(pend_cnt), 3);
        tgl_in = ~tgl_in;
        repeat (2) @(negedge clk);
        evt_ready = 1'b1;
        @(posedge clk); #2 chk("t5_pend3_hold", int'(pend_cnt), 3);
        chk("t5_pulse3", int'(evt_pulse), 1);
        @(negedge clk); evt_ready = 1'b0;

        // 6: asynchronous reset with 7 pending, toggle during warm-up absorbed
        repeat (4) @(negedge clk);
        toggles(4);
        chk("t6_pend7", int'(pend_cnt), 7);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t6_async_pend",  int'(pend_cnt),  0);
        chk("t6_async_valid", int'(evt_valid), 0);
        chk("t6_async_tot",   int'(tot_cnt),   0);
        chk("t6_async_pulse", int'(evt_pulse), 0);
        chk("t6_async_state", int'(dbg_state), 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        tgl_in = ~tgl_in;
        base = pulse_seen;
        repeat (12) @(negedge clk);
        chk("t6_warm_pulses", pulse_seen - base, 0);
        chk("t6_warm_pend", int'(pend_cnt), 0);
        toggles(1);
        chk("t6_after_pend", int'(pend_cnt), 1);
        chk("t6_after_tot", int'(tot_cnt), 1);

        repeat (2) @(negedge clk);
        finish_run();
    end

    // Watchdog: the run must end on its own.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        finish_run();
    end

endmodule
